// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the calculator datapath and the accumulator ALU.
interface alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] inputP;
    logic [WIDTH-1:0] inputQ;
    logic [3:0]       opCode;
    logic [WIDTH-1:0] outALU;
    logic [1:0]       errorCode;

    modport master (
        output inputP, inputQ, opCode,
        input  outALU, errorCode
    );

    modport slave (
        input  inputP, inputQ, opCode,
        output outALU, errorCode
    );
endinterface

// File: rtl/alu.sv
// Accumulator ALU: every clock edge applies opCode to ACC and P/Q; ACC drives outALU
// directly so operations chain, errorCode reports the status of the latest operation.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    localparam int unsigned DW  = 2 * WIDTH;
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIVZ = 2'b10;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_MUL   = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_MOD   = 4'b0101,
        OP_AND   = 4'b0110,
        OP_OR    = 4'b0111,
        OP_XOR   = 4'b1000,
        OP_NOT   = 4'b1001,
        OP_SHL   = 4'b1010,
        OP_SHR   = 4'b1011,
        OP_CLEAR = 4'b1100,
        OP_LOAD  = 4'b1101,
        OP_MULPQ = 4'b1110,
        OP_POW   = 4'b1111
    } op_e;

    logic [WIDTH-1:0] acc;
    logic [1:0]       err;
    logic [WIDTH-1:0] nextAcc;
    logic [1:0]       nextErr;
    logic [WIDTH-1:0] powRes;
    logic             powOvf;

    op_e              op;
    logic [WIDTH-1:0] opP;
    logic [WIDTH-1:0] opQ;

    assign op  = op_e'(bus.opCode);
    assign opP = bus.inputP;
    assign opQ = bus.inputQ;

    // Square-and-multiply over every bit of Q, tracking true magnitude beyond WIDTH bits.
    // The base only counts as overflowed once a later multiply actually consumes it.
    always_comb begin
        logic [WIDTH-1:0] base;
        logic             baseBig;
        logic [DW-1:0]    prod;
        powRes  = WIDTH'(1);
        powOvf  = 1'b0;
        base    = opP;
        baseBig = 1'b0;
        prod    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (opQ[i]) begin
                prod = DW'(powRes) * DW'(base);
                if ((|prod[DW-1:WIDTH]) || baseBig) begin
                    powOvf = 1'b1;
                end
                powRes = prod[WIDTH-1:0];
            end
            prod = DW'(base) * DW'(base);
            if (|prod[DW-1:WIDTH]) begin
                baseBig = 1'b1;
            end
            base = prod[WIDTH-1:0];
        end
    end

    // Next accumulator value and status for the current opcode.
    always_comb begin
        logic [DW-1:0] wide;
        nextAcc = acc;
        nextErr = ERR_OK;
        wide    = '0;
        unique case (op)
            OP_NOP:   nextAcc = acc;
            OP_ADD: begin
                wide    = DW'(acc) + DW'(opP);
                nextAcc = wide[WIDTH-1:0];
                if (|wide[DW-1:WIDTH]) nextErr = ERR_OVF;
            end
            OP_MUL: begin
                wide    = DW'(acc) * DW'(opP);
                nextAcc = wide[WIDTH-1:0];
                if (|wide[DW-1:WIDTH]) nextErr = ERR_OVF;
            end
            OP_DIV: begin
                if (opP == '0) nextErr = ERR_DIVZ;
                else           nextAcc = acc / opP;
            end
            OP_SUB: begin
                nextAcc = acc - opP;
                if (opP > acc) nextErr = ERR_OVF;
            end
            OP_MOD: begin
                if (opP == '0) nextErr = ERR_DIVZ;
                else           nextAcc = acc % opP;
            end
            OP_AND:   nextAcc = acc & opP;
            OP_OR:    nextAcc = acc | opP;
            OP_XOR:   nextAcc = acc ^ opP;
            OP_NOT:   nextAcc = ~acc;
            OP_SHL:   nextAcc = acc << opP[SHW-1:0];
            OP_SHR:   nextAcc = acc >> opP[SHW-1:0];
            OP_CLEAR: nextAcc = '0;
            OP_LOAD:  nextAcc = opP;
            OP_MULPQ: begin
                wide    = DW'(opP) * DW'(opQ);
                nextAcc = wide[WIDTH-1:0];
                if (|wide[DW-1:WIDTH]) nextErr = ERR_OVF;
            end
            OP_POW: begin
                nextAcc = powRes;
                if (powOvf) nextErr = ERR_OVF;
            end
            default: begin
                nextAcc = acc;
                nextErr = ERR_OK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            err <= ERR_OK;
        end else begin
            acc <= nextAcc;
            err <= nextErr;
        end
    end

    assign bus.outALU    = acc;
    assign bus.errorCode = err;
endmodule

// File: tb/tb_alu.sv
// Directed vector bench for the accumulator ALU: a table of one-edge steps plus
// hand-written reset and held-opcode sequences.
module tb_alu;
    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, MUL = 4'h2, DIV = 4'h3,
                           SUB = 4'h4, MOD = 4'h5, AND = 4'h6, OR  = 4'h7,
                           XOR = 4'h8, NOT = 4'h9, SHL = 4'hA, SHR = 4'hB,
                           CLR = 4'hC, LD  = 4'hD, MPQ = 4'hE, POW = 4'hF;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] expOut;
        logic [1:0]       expErr;
    } vec_t;

    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;
    vec_t vecs[$];

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic [3:0] op, logic [WIDTH-1:0] p, logic [WIDTH-1:0] q,
                                   logic [WIDTH-1:0] expOut, logic [1:0] expErr);
        vec_t v;
        v.op = op; v.p = p; v.q = q; v.expOut = expOut; v.expErr = expErr;
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] expOut, input logic [1:0] expErr);
        nCompared++;
        if (bus.outALU !== expOut) begin
            nMismatched++;
            $display("FAIL %s outALU: got %h, expected %h", name, bus.outALU, expOut);
        end
        nCompared++;
        if (bus.errorCode !== expErr) begin
            nMismatched++;
            $display("FAIL %s errorCode: got %b, expected %b", name, bus.errorCode, expErr);
        end
    endtask

    // One edge with the given inputs; outputs sampled just after the edge.
    task automatic step(input logic [3:0] op, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
        @(negedge clk);
        bus.opCode = op;
        bus.inputP = p;
        bus.inputQ = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;

        vecs.push_back(mkVec(CLR, 32'd0,          32'd0,    32'd0,          2'b00));
        vecs.push_back(mkVec(POW, 32'd12,         32'd2,    32'd144,        2'b00));
        vecs.push_back(mkVec(MUL, 32'd3141,       32'd0,    32'd452304,     2'b00));
        vecs.push_back(mkVec(DIV, 32'd1000,       32'd0,    32'd452,        2'b00));
        vecs.push_back(mkVec(LD,  32'hFFFFFFFF,   32'd0,    32'hFFFFFFFF,   2'b00));
        vecs.push_back(mkVec(ADD, 32'd1,          32'd0,    32'd0,          2'b01));
        vecs.push_back(mkVec(ADD, 32'd1,          32'd0,    32'd1,          2'b00));
        vecs.push_back(mkVec(LD,  32'd10,         32'd0,    32'd10,         2'b00));
        vecs.push_back(mkVec(DIV, 32'd0,          32'd0,    32'd10,         2'b10));
        vecs.push_back(mkVec(MOD, 32'd3,          32'd0,    32'd1,          2'b00));
        vecs.push_back(mkVec(POW, 32'd2,          32'd32,   32'd0,          2'b01));
        vecs.push_back(mkVec(POW, 32'd0,          32'd0,    32'd1,          2'b00));
        vecs.push_back(mkVec(POW, 32'd1,          32'd1000, 32'd1,          2'b00));
        vecs.push_back(mkVec(LD,  32'd1,          32'd0,    32'd1,          2'b00));
        vecs.push_back(mkVec(SHL, 32'd31,         32'd0,    32'h80000000,   2'b00));
        vecs.push_back(mkVec(SHR, 32'd4,          32'd0,    32'h08000000,   2'b00));
        vecs.push_back(mkVec(NOT, 32'd0,          32'd0,    32'hF7FFFFFF,   2'b00));
        vecs.push_back(mkVec(NOP, 32'd123,        32'd0,    32'hF7FFFFFF,   2'b00));
        vecs.push_back(mkVec(NOP, 32'd0,          32'd7,    32'hF7FFFFFF,   2'b00));
        vecs.push_back(mkVec(LD,  32'd5,          32'd0,    32'd5,          2'b00));
        vecs.push_back(mkVec(SUB, 32'd7,          32'd0,    32'hFFFFFFFE,   2'b01));
        vecs.push_back(mkVec(SUB, 32'd14,         32'd0,    32'hFFFFFFF0,   2'b00));
        vecs.push_back(mkVec(LD,  32'h00010000,   32'd0,    32'h00010000,   2'b00));
        vecs.push_back(mkVec(MUL, 32'h00010000,   32'd0,    32'd0,          2'b01));
        vecs.push_back(mkVec(MPQ, 32'h00012345,   32'h100,  32'h01234500,   2'b00));
        vecs.push_back(mkVec(MPQ, 32'h80000000,   32'd2,    32'd0,          2'b01));
        vecs.push_back(mkVec(LD,  32'hF0F0F0F0,   32'd0,    32'hF0F0F0F0,   2'b00));
        vecs.push_back(mkVec(AND, 32'h0FF00FF0,   32'd0,    32'h00F000F0,   2'b00));
        vecs.push_back(mkVec(OR,  32'h0000000F,   32'd0,    32'h00F000FF,   2'b00));
        vecs.push_back(mkVec(XOR, 32'h000000FF,   32'd0,    32'h00F00000,   2'b00));
        vecs.push_back(mkVec(MOD, 32'd0,          32'd0,    32'h00F00000,   2'b10));
        vecs.push_back(mkVec(SHR, 32'd36,         32'd0,    32'h00F00000 >> 4, 2'b00));
        vecs.push_back(mkVec(POW, 32'd3,          32'd20,   32'hCFD41B91,   2'b00));
        vecs.push_back(mkVec(POW, 32'd3,          32'd21,   32'h6F7C52B3,   2'b01));
        vecs.push_back(mkVec(POW, 32'd2,          32'd31,   32'h80000000,   2'b00));
        vecs.push_back(mkVec(POW, 32'd2,          32'd16,   32'h00010000,   2'b00));
        vecs.push_back(mkVec(POW, 32'd65536,      32'd2,    32'd0,          2'b01));
        vecs.push_back(mkVec(POW, 32'd0,          32'd40,   32'd0,          2'b00));

        reset      = 1'b1;
        bus.opCode = NOP;
        bus.inputP = '0;
        bus.inputQ = '0;
        #1;
        check("reset_initial", 32'd0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].p, vecs[i].q);
            check($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].expOut, vecs[i].expErr);
        end

        // Held opcode accumulates once per edge.
        step(CLR, 32'd0, 32'd0);
        check("hold_clear", 32'd0, 2'b00);
        step(ADD, 32'd2, 32'd0);
        check("hold_add1", 32'd2, 2'b00);
        @(posedge clk); #1;
        check("hold_add2", 32'd4, 2'b00);
        @(posedge clk); #1;
        check("hold_add3", 32'd6, 2'b00);

        // Asynchronous reset mid-sequence, mid-cycle, with an error pending.
        step(LD, 32'd5, 32'd0);
        check("pre_reset_load", 32'd5, 2'b00);
        @(negedge clk);
        bus.opCode = DIV;
        bus.inputP = 32'd0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_acc5", 32'd0, 2'b00);
        bus.opCode = LD;
        bus.inputP = 32'd9;
        @(posedge clk); #1;
        check("reset_held_over_edge", 32'd0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_load", 32'd9, 2'b00);

        step(ADD, 32'hFFFFFFFF, 32'd0);
        check("pre_reset_ovf", 32'd8, 2'b01);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_clears_err", 32'd0, 2'b00);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
